// File: rtl/gate_resp_checker.sv
// Response checker for two-input gate lab designs: compares each accepted
// {ain,bin,yout} vector against a latched reference function and tracks coverage.
module gate_resp_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op_sel,
  input  logic             vld,
  input  logic             ain,
  input  logic             bin,
  input  logic             yout,
  output logic             rdy,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       cov,
  output logic             err,
  output logic [2:0]       first_fail,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DONE} state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic             r_rdy;
  logic             r_done;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [3:0]       r_cov;
  logic             r_err;
  logic [2:0]       r_first_fail;

  logic       w_accept;
  logic       w_exp;
  logic [3:0] w_cov_nxt;

  always_comb begin
    w_exp = 1'b0;
    case (r_op)
      2'b00:   w_exp = ain & bin;
      2'b01:   w_exp = ain | bin;
      2'b10:   w_exp = ain ^ bin;
      default: w_exp = ~(ain ^ bin);
    endcase
  end

  // rdy is asserted exactly while in CHECK, so it doubles as the accept qualifier
  assign w_accept  = vld & r_rdy;
  assign w_cov_nxt = r_cov | (4'b0001 << {ain, bin});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_rdy        <= 1'b0;
      r_done       <= 1'b0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
      r_cov        <= '0;
      r_err        <= 1'b0;
      r_first_fail <= '0;
    end else if (start) begin
      r_state      <= S_CHECK;
      r_op         <= op_sel;
      r_rdy        <= 1'b1;
      r_done       <= 1'b0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
      r_cov        <= '0;
      r_err        <= 1'b0;
      r_first_fail <= '0;
    end else if (w_accept) begin
      if (yout == w_exp) begin
        if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 1'b1;
      end else begin
        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
        if (!r_err) r_first_fail <= {ain, bin, yout};
        r_err <= 1'b1;
      end
      r_cov <= w_cov_nxt;
      if (w_cov_nxt == 4'hF) begin
        r_state <= S_DONE;
        r_rdy   <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  assign rdy        = r_rdy;
  assign done       = r_done;
  assign pass_cnt   = r_pass_cnt;
  assign fail_cnt   = r_fail_cnt;
  assign cov        = r_cov;
  assign err        = r_err;
  assign first_fail = r_first_fail;

endmodule
